aes_key_expander: RTL and testbench

//  Sequential AES key schedule engine (FIPS-197) for AES-128/192/256, selected by parameter.

---
 rtl/aes_key_expander_if.sv | 44 ++++
 rtl/aes_key_expander.sv | 193 +++++++++++++++++++
 tb/tb_aes_key_expander.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expander_if.sv
// ---------------------------------------------------------------------------
// aes_key_expander_if
// Bundles the control and round-key streaming signals of aes_key_expander.
//
// Handshake: the expander (slave modport) raises rk_valid with rk_data and
// rk_index.
//   - It holds all three stable until the consumer samples rk_ready high on
//     a rising edge.
//   - That edge is the transfer.
//   - rk_valid never drops without a transfer.
//   - rk_ready has no effect while rk_valid is low.
//
// Signals:
//   start     requester -> expander  begin an expansion (seen only in IDLE)
//   key_in    requester -> expander  cipher key, w0 in the top 32 bits
//   busy      expander  -> requester expansion in progress
//   rk_valid  expander  -> consumer  round key on rk_data
//   rk_ready  consumer  -> expander  consumer accepts the round key
//   rk_data   expander  -> consumer  {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   rk_index  expander  -> consumer  round number r
//   done      expander  -> requester one-cycle pulse after the last round key
// ---------------------------------------------------------------------------
interface aes_key_expander_if #(
  parameter int KEY_BITS = 128
);
  logic                start;
  logic [KEY_BITS-1:0] key_in;
  logic                busy;
  logic                rk_valid;
  logic                rk_ready;
  logic [127:0]        rk_data;
  logic [3:0]          rk_index;
  logic                done;

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_data, rk_index, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_data, rk_index, done
  );
endinterface

// File: rtl/aes_key_expander.sv
// ---------------------------------------------------------------------------
// aes_key_expander
// Sequential AES key schedule for AES-128/192/256 (KEY_BITS = 128/192/256).
// One 32-bit schedule word is produced per GEN cycle. Each group of four
// words is presented as a 128-bit round key, and the round keys 0..Nr are
// streamed over a valid/ready handshake.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   io_kx        aes_key_expander_if.slave (start/key_in/busy/rk_*/done)
//   o_dbg_state  current FSM state (0 IDLE, 1 GEN, 2 OUT, 3 DONE)
// ---------------------------------------------------------------------------
module aes_key_expander #(
  parameter int KEY_BITS = 128
) (
  input  logic               clk,
  input  logic               rst,
  aes_key_expander_if.slave  io_kx,
  output logic [1:0]         o_dbg_state
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam logic [5:0] NK_I    = 6'(NK);
  localparam logic [2:0] NK_LAST = 3'(NK - 1);
  localparam logic [3:0] NR_IDX  = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_OUT  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;

  // r_win[0] is the oldest word of the Nk-word window, r_win[NK-1] the newest.
  logic [31:0]   r_win [NK];
  logic [127:0]  r_asm;        // assembly buffer, also drives rk_data
  logic [3:0]    r_rk_index;
  logic [5:0]    r_i;          // schedule word number i
  logic [2:0]    r_mod;        // i % Nk
  logic [1:0]    r_grp;        // word position inside the current group
  logic [7:0]    r_rcon;

  logic          w_load;
  logic          w_gen;
  logic          w_xfer;
  logic          w_expand;
  logic          w_rcon_step;
  logic [31:0]   w_prev;
  logic [31:0]   w_t;
  logic [31:0]   w_word;

  // ---------------------------------------------------------------- GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, which also maps 0 to 0)
  // followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, b;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    b    = gf_mul(x252, x2);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // -------------------------------------------------------------- word rule
  // For i < Nk the window is rotated instead of updated.
  //   - The emitted word is the key word itself.
  //   - After Nk rotations the window again holds w0..w(Nk-1).
  //   - That is exactly w[i-Nk..i-1] for i = Nk.
  always_comb begin
    w_prev      = r_win[NK-1];
    w_expand    = (r_i >= NK_I);
    w_rcon_step = w_expand && (r_mod == 3'd0);
    w_t         = w_prev;
    if (r_mod == 3'd0) begin
      w_t = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
    end else if ((KEY_BITS == 256) && (r_mod == 3'd4)) begin
      w_t = sub_word(w_prev);
    end
    w_word = w_expand ? (r_win[0] ^ w_t) : r_win[0];
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_load         = 1'b0;
    w_gen          = 1'b0;
    w_xfer         = 1'b0;
    io_kx.busy     = 1'b0;
    io_kx.rk_valid = 1'b0;
    io_kx.done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_kx.start) begin
          w_load = 1'b1;
          w_next = S_GEN;
        end
      end
      S_GEN: begin
        io_kx.busy = 1'b1;
        w_gen      = 1'b1;
        if (r_grp == 2'd3) w_next = S_OUT;
      end
      S_OUT: begin
        io_kx.busy     = 1'b1;
        io_kx.rk_valid = 1'b1;
        if (io_kx.rk_ready) begin
          w_xfer = 1'b1;
          w_next = (r_rk_index == NR_IDX) ? S_DONE : S_GEN;
        end
      end
      S_DONE: begin
        io_kx.done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NK; k++) r_win[k] <= 32'h0;
      r_asm      <= 128'h0;
      r_rk_index <= 4'd0;
      r_i        <= 6'd0;
      r_mod      <= 3'd0;
      r_grp      <= 2'd0;
      r_rcon     <= 8'h01;
    end else begin
      if (w_load) begin
        for (int k = 0; k < NK; k++) r_win[k] <= io_kx.key_in[KEY_BITS-1-32*k -: 32];
        r_rk_index <= 4'd0;
        r_i        <= 6'd0;
        r_mod      <= 3'd0;
        r_grp      <= 2'd0;
        r_rcon     <= 8'h01;
      end
      if (w_gen) begin
        for (int k = 0; k < NK - 1; k++) r_win[k] <= r_win[k+1];
        r_win[NK-1] <= w_word;
        r_asm       <= {r_asm[95:0], w_word};
        r_i         <= r_i + 6'd1;
        r_mod       <= (r_mod == NK_LAST) ? 3'd0 : r_mod + 3'd1;
        r_grp       <= r_grp + 2'd1;
        if (w_rcon_step) r_rcon <= xtime(r_rcon);
      end
      if (w_xfer && (r_rk_index != NR_IDX)) r_rk_index <= r_rk_index + 4'd1;
    end
  end

  assign io_kx.rk_data  = r_asm;
  assign io_kx.rk_index = r_rk_index;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_aes_key_expander.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expander
// Directed bench for aes_key_expander at all three key sizes.
// One DUT is instantiated per KEY_BITS value. They share clk, rst and
// rk_ready. sel routes start to one DUT and selects which outputs are
// observed.
// ---------------------------------------------------------------------------
module tb_aes_key_expander;

  // ------------------------------------------------------ clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------------ DUT hookup
  logic         tb_start;
  logic         tb_ready;
  int           sel;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;

  aes_key_expander_if #(.KEY_BITS(128)) if128 ();
  aes_key_expander_if #(.KEY_BITS(192)) if192 ();
  aes_key_expander_if #(.KEY_BITS(256)) if256 ();

  assign if128.start    = tb_start && (sel == 0);
  assign if192.start    = tb_start && (sel == 1);
  assign if256.start    = tb_start && (sel == 2);
  assign if128.key_in   = key128;
  assign if192.key_in   = key192;
  assign if256.key_in   = key256;
  assign if128.rk_ready = tb_ready;
  assign if192.rk_ready = tb_ready;
  assign if256.rk_ready = tb_ready;

  logic [1:0] st128, st192, st256;

  aes_key_expander #(.KEY_BITS(128)) u_dut128 (.clk(clk), .rst(rst), .io_kx(if128), .o_dbg_state(st128));
  aes_key_expander #(.KEY_BITS(192)) u_dut192 (.clk(clk), .rst(rst), .io_kx(if192), .o_dbg_state(st192));
  aes_key_expander #(.KEY_BITS(256)) u_dut256 (.clk(clk), .rst(rst), .io_kx(if256), .o_dbg_state(st256));

  logic         m_valid, m_busy, m_done;
  logic [127:0] m_data;
  logic [3:0]   m_index;
  logic [1:0]   m_state;

  always_comb begin
    m_valid = if128.rk_valid;
    m_busy  = if128.busy;
    m_done  = if128.done;
    m_data  = if128.rk_data;
    m_index = if128.rk_index;
    m_state = st128;
    case (sel)
      1: begin
        m_valid = if192.rk_valid; m_busy = if192.busy; m_done = if192.done;
        m_data  = if192.rk_data;  m_index = if192.rk_index; m_state = st192;
      end
      2: begin
        m_valid = if256.rk_valid; m_busy = if256.busy; m_done = if256.done;
        m_data  = if256.rk_data;  m_index = if256.rk_index; m_state = st256;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------- checker
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // ------------------------------------------------------------- collector
  // Sampled on the falling edge; valid && ready here means the transfer
  // happens on the next rising edge.
  logic [127:0] got_data [128];
  logic [3:0]   got_idx  [128];
  int           done_cyc [16];
  int           n_got  = 0;
  int           n_done = 0;
  logic         chk_stable = 1'b0;
  logic         hold_pend  = 1'b0;
  logic [127:0] hold_data;
  logic [3:0]   hold_idx;

  always @(negedge clk) begin
    if (chk_stable && hold_pend) begin
      check("hold_valid", 128'(m_valid), 128'd1);
      check("hold_data", m_data, hold_data);
      check("hold_index", 128'(m_index), 128'(hold_idx));
    end
    hold_pend <= m_valid && !tb_ready && !rst;
    hold_data <= m_data;
    hold_idx  <= m_index;
    if (!rst && m_valid && tb_ready && (n_got < 128)) begin
      got_data[n_got] <= m_data;
      got_idx[n_got]  <= m_index;
      n_got           <= n_got + 1;
    end
    if (!rst && m_done && (n_done < 16)) begin
      done_cyc[n_done] <= cyc;
      n_done           <= n_done + 1;
    end
  end

  // ------------------------------------------------------------ scoreboard
  // FIPS-197 appendix A.1 round keys for key 2b7e1516...
  logic [127:0] r128 [11];
  logic [127:0] exp_q [$];

  task automatic push_exp128();
    for (int j = 0; j < 11; j++) exp_q.push_back(r128[j]);
  endtask

  task automatic score128(input string tag, input int base, input int cnt);
    logic [127:0] e;
    check({tag, "_count"}, 128'(n_got - base), 128'(cnt));
    for (int j = 0; j < cnt; j++) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, got_data[base+j], e);
      check({tag, "_index"}, 128'(got_idx[base+j]), 128'(j % 11));
    end
  endtask

  // ---------------------------------------------------------------- driver
  // mode 0: rk_ready tied high; mode 1: rk_ready high about 30% of cycles.
  task automatic run_exp(input int s, input int mode,
                         output int base_got, output int base_done, output int start_cyc);
    base_got  = n_got;
    base_done = n_done;
    sel       = s;
    tb_start  = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    tb_start = 1'b0;
    check("busy_after_start", 128'(m_busy), 128'd1);
    for (int c = 0; (c < 3000) && (n_done == base_done); c++) begin
      tb_ready = (mode == 1) ? ($urandom_range(0, 99) < 30) : 1'b1;
      @(posedge clk); #1;
    end
    repeat (10) @(posedge clk);
    #1;
    check("one_done", 128'(n_done - base_done), 128'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 128'(m_valid), 128'd0);
    check({tag, "_busy"},  128'(m_busy),  128'd0);
    check({tag, "_done"},  128'(m_done),  128'd0);
    check({tag, "_data"},  m_data,        128'd0);
    check({tag, "_index"}, 128'(m_index), 128'd0);
    check({tag, "_state"}, 128'(m_state), 128'd0);
  endtask

  // ----------------------------------------------------------------- tests
  initial begin
    int bg, bd, sc;
    r128 = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
             128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
             128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
             128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
             128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
             128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    key128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    key256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    rst      = 1'b1;
    tb_start = 1'b0;
    tb_ready = 1'b0;
    sel      = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_idle_outputs("reset");
    end
    sel = 0;

    // T1: AES-128, rk_ready high
    push_exp128();
    run_exp(0, 0, bg, bd, sc);
    check("t1_latency", 128'(done_cyc[bd] - sc), 128'd56);
    score128("t1", bg, 11);

    // T2: AES-192
    run_exp(1, 0, bg, bd, sc);
    check("t2_latency", 128'(done_cyc[bd] - sc), 128'd66);
    check("t2_count", 128'(n_got - bg), 128'd13);
    check("t2_r0", got_data[bg], key192[191:64]);
    check("t2_r1_hi", 128'(got_data[bg+1][127:64]), 128'(key192[63:0]));
    check("t2_r12", got_data[bg+12], 128'he98ba06f448c773c8ecc720401002202);
    check("t2_r12_index", 128'(got_idx[bg+12]), 128'd12);

    // T3: AES-256
    run_exp(2, 0, bg, bd, sc);
    check("t3_latency", 128'(done_cyc[bd] - sc), 128'd76);
    check("t3_count", 128'(n_got - bg), 128'd15);
    check("t3_r0", got_data[bg], key256[255:128]);
    check("t3_r1", got_data[bg+1], key256[127:0]);
    check("t3_w8", 128'(got_data[bg+2][127:96]), 128'h9ba35411);
    check("t3_r14", got_data[bg+14], 128'hfe4890d1e6188d0b046df344706c631e);
    check("t3_r14_index", 128'(got_idx[bg+14]), 128'd14);

    // T4: AES-128 under random backpressure, key changed after acceptance
    chk_stable = 1'b1;
    push_exp128();
    fork
      begin
        @(posedge clk); @(posedge clk); #2;
        key128 = ~key128;
      end
    join_none
    run_exp(0, 1, bg, bd, sc);
    chk_stable = 1'b0;
    key128     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    score128("t4", bg, 11);

    // T5: reset while round key 3 is waiting in OUT, then a clean rerun
    sel      = 0;
    bg       = n_got;
    bd       = n_done;
    tb_ready = 1'b1;
    tb_start = 1'b1;
    @(posedge clk); #1;
    tb_start = 1'b0;
    for (int c = 0; (c < 200) && (n_got - bg < 3); c++) begin
      @(posedge clk); #1;
    end
    tb_ready = 1'b0;
    for (int c = 0; (c < 50) && !m_valid; c++) begin
      @(posedge clk); #1;
    end
    check("t5_pre_valid", 128'(m_valid), 128'd1);
    check("t5_pre_index", 128'(m_index), 128'd3);
    rst = 1'b1;
    #1;
    check_idle_outputs("t5_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_done", 128'(n_done - bd), 128'd0);
    check("t5_no_extra_rk", 128'(n_got - bg), 128'd3);
    push_exp128();
    run_exp(0, 0, bg, bd, sc);
    check("t5_latency", 128'(done_cyc[bd] - sc), 128'd56);
    score128("t5", bg, 11);

    // T6: start held high; one expansion per IDLE entry
    sel      = 0;
    bg       = n_got;
    bd       = n_done;
    tb_ready = 1'b1;
    tb_start = 1'b1;
    for (int c = 0; (c < 400) && (n_done - bd < 2); c++) begin
      @(posedge clk); #1;
    end
    tb_start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("t6_dones", 128'(n_done - bd), 128'd2);
    check("t6_period", 128'(done_cyc[bd+1] - done_cyc[bd]), 128'd57);
    check("t6_idle_busy", 128'(m_busy), 128'd0);
    check("t6_idle_state", 128'(m_state), 128'd0);
    push_exp128();
    push_exp128();
    score128("t6", bg, 22);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
